// File: rtl/gate_input_debouncer.sv
// Gate input conditioner: two-flop synchroniser plus an independent counter-based
// debouncer per channel, with registered clean levels, edge pulses and a busy flag.
module gate_input_debouncer #(
  parameter int N_CH            = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit RESET_LEVEL     = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic            busy
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    STABLE = 1'b0,
    COUNT  = 1'b1
  } state_t;

  logic [N_CH-1:0] sync1_reg;
  logic [N_CH-1:0] sync2_reg;
  logic [N_CH-1:0] counting_next;
  logic            busy_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg <= {N_CH{RESET_LEVEL}};
      sync2_reg <= {N_CH{RESET_LEVEL}};
      busy_reg  <= 1'b0;
    end else begin
      sync1_reg <= raw_in;
      sync2_reg <= sync1_reg;
      busy_reg  <= |counting_next;
    end
  end

  assign busy = busy_reg;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      state_t          state_reg, state_next;
      logic [CW-1:0]   cnt_reg, cnt_next;
      logic            clean_reg, clean_next;
      logic            rise_reg, rise_next;
      logic            fall_reg, fall_next;
      logic            sample;

      assign sample = sync2_reg[gi];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_reg <= STABLE;
          cnt_reg   <= '0;
          clean_reg <= RESET_LEVEL;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          clean_reg <= clean_next;
          rise_reg  <= rise_next;
          fall_reg  <= fall_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        clean_next = clean_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state_reg)
          STABLE: begin
            cnt_next = '0;
            if (sample != clean_reg) begin
              // A one-sample debounce accepts the new level without entering COUNT.
              if (DEBOUNCE_CYCLES == 1) begin
                clean_next = sample;
                rise_next  = sample;
                fall_next  = ~sample;
              end else begin
                state_next = COUNT;
                cnt_next   = CW'(1);
              end
            end
          end
          COUNT: begin
            if (sample == clean_reg) begin
              state_next = STABLE;
              cnt_next   = '0;
            end else if (cnt_reg == CNT_MAX) begin
              state_next = STABLE;
              cnt_next   = '0;
              clean_next = sample;
              rise_next  = sample;
              fall_next  = ~sample;
            end else begin
              cnt_next = cnt_reg + CW'(1);
            end
          end
          default: begin
            state_next = STABLE;
            cnt_next   = '0;
          end
        endcase
      end

      assign counting_next[gi] = (state_next == COUNT);
      assign clean_out[gi]     = clean_reg;
      assign rise_pulse[gi]    = rise_reg;
      assign fall_pulse[gi]    = fall_reg;
    end
  endgenerate

endmodule
